// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: stage payload widths, the NOP used as a bubble
// and the occupancy encoding of a valid/ready stage register.
package pipeline_pkg;

    // Payload widths of the four boundary registers.
    localparam int IFID_W  = 64;   // {instruction, pc_plus_4}
    localparam int IDEX_W  = 160;
    localparam int EXMEM_W = 112;
    localparam int MEMWB_W = 72;

    // addi x0, x0, 0 -- what a consumer that ignores valid sees in a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Stage occupancy. Bit 0 = main register live, bit 1 = skid register live,
    // so the flags can be read straight out of the state.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline boundary register with optional 2-entry
// skid buffer, synchronous flush with bubble insertion and a saturating
// stall-cycle counter.
module pipe_stage_reg
    import pipeline_pkg::*;
#(
    parameter int                DATA_W       = 64,
    parameter int                SKID         = 1,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = '0,
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_count
);

    logic accept;
    logic emit;
    logic alive_q;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // Out-of-reset flag: keeps in_ready low while reset is held and for the
    // first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) alive_q <= 1'b0;
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        else        alive_q <= 1'b1;
    end

    // Saturating count of edges where the consumer stalled a live payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0]        state_q, state_d;
            logic [DATA_W-1:0] m_q, m_d;
            logic [DATA_W-1:0] s_q, s_d;

            // in_ready comes from flops only, never from out_ready.
            assign in_ready  = alive_q & ~state_q[1];
            assign out_valid = state_q[0];
            assign out_data  = m_q;

            // Next-state for the main/skid pair; flush overrides everything.
            always_comb begin
                // NOTE: defaults first so no path leaves a variable unassigned (no latch).
                state_d = state_q;
                m_d     = m_q;
                s_d     = s_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                    m_d     = BUBBLE_VALUE;
                    s_d     = BUBBLE_VALUE;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (accept) begin
                                state_d = ST_ONE;
                                m_d     = in_data;
                            end
                        end
                        ST_ONE: begin
                            if (accept && emit) begin
                                m_d = in_data;
                            end else if (emit) begin
                                state_d = ST_EMPTY;
                                m_d     = BUBBLE_VALUE;
                            end else if (accept) begin
                                state_d = ST_FULL;
                                s_d     = in_data;
                            end
                        end
                        ST_FULL: begin
                            if (emit) begin
                                state_d = ST_ONE;
                                m_d     = s_q;
                                s_d     = BUBBLE_VALUE;
                            end
                        end
                        default: begin
                            state_d = ST_EMPTY;
                            m_d     = BUBBLE_VALUE;
                            s_d     = BUBBLE_VALUE;
                        end
                    endcase
                end
            end

            // Stage state and payload registers.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= ST_EMPTY;
                    // NOTE: payload registers are reset too, so out_data shows the bubble during reset.
                    m_q     <= BUBBLE_VALUE;
                    s_q     <= BUBBLE_VALUE;
                end else begin
                    state_q <= state_d;
                    m_q     <= m_d;
                    s_q     <= s_d;
                end
            end
        end else begin : g_plain
            logic              valid_q;
            logic [DATA_W-1:0] m_q;

            // Without a skid slot, a full stage can only take a payload when
            // the current one leaves in the same cycle.
            assign in_ready  = alive_q & (~valid_q | out_ready);
            assign out_valid = valid_q;
            assign out_data  = m_q;

            // Single register: flush, then load, then drain to the bubble.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_q <= 1'b0;
                    m_q     <= BUBBLE_VALUE;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    m_q     <= BUBBLE_VALUE;
                end else if (accept) begin
                    valid_q <= 1'b1;
                    m_q     <= in_data;
                end else if (emit) begin
                    valid_q <= 1'b0;
                    m_q     <= BUBBLE_VALUE;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a 64-bit skid stage, a 4-bit-counter skid
// stage for saturation and a plain (SKID=0) stage.
module tb_pipe_stage_reg;
    import pipeline_pkg::*;

    localparam logic [63:0] BUB64 = {NOP_INSTR, 32'h0};
    localparam logic [7:0]  BUB8  = 8'h13;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic reset = 1'b0;

    // 64-bit skid stage
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [63:0] in_data = '0, out_data;
    logic [15:0] stall_count;

    // 8-bit skid stage with 4-bit counter
    logic       s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic       s_in_ready, s_out_valid;
    logic [7:0] s_in_data = '0, s_out_data;
    logic [3:0] s_stall_count;

    // 8-bit plain stage
    logic       p_flush = 1'b0, p_in_valid = 1'b0, p_out_ready = 1'b0;
    logic       p_in_ready, p_out_valid;
    logic [7:0] p_in_data = '0, p_out_data;
    logic [7:0] p_stall_count;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .BUBBLE_VALUE(BUB64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_count(stall_count)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID(1), .BUBBLE_VALUE(BUB8), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_count(s_stall_count)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID(0), .BUBBLE_VALUE(BUB8), .CNT_W(8)) dut_plain (
        .clk(clk), .reset(reset), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .stall_count(p_stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = 64'hFFFF; s_in_valid = 1'b1; p_in_valid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== BUB64) begin errors++; $display("FAIL reset_out_data got %h want %h", out_data, BUB64); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
        checks++; if (p_in_ready !== 1'b0) begin errors++; $display("FAIL reset_plain_in_ready got %b want 0", p_in_ready); end
        checks++; if (s_out_data !== BUB8) begin errors++; $display("FAIL reset_sat_out_data got %h want %h", s_out_data, BUB8); end
        in_valid = 1'b0; s_in_valid = 1'b0; p_in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        logic [63:0] exp_d;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8);
            in_data  = 64'h11 + 64'(k);
            exp_d    = (k >= 1 && k <= 8) ? 64'h11 + 64'(k - 1) : BUB64;
            @(negedge clk);
            checks++; if (out_valid !== (k >= 1 && k <= 8)) begin errors++; $display("FAIL stream_valid[%0d] got %b want %b", k, out_valid, (k >= 1 && k <= 8)); end
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", k, out_data, exp_d); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b want 1", k, in_ready); end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic        iv_t [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic [63:0] id_t [8] = '{64'hA, 64'hB, 64'hC, 64'hC, 64'hC, 64'hC, 64'h0, 64'h0};
        logic        or_t [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic        ov_t [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic [63:0] od_t [8] = '{BUB64, 64'hA, 64'hA, 64'hA, 64'hA, 64'hB, 64'hC, BUB64};
        logic        ir_t [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        for (int c = 0; c < 8; c++) begin
            in_valid = iv_t[c]; in_data = id_t[c]; out_ready = or_t[c];
            @(negedge clk);
            checks++; if (out_valid !== ov_t[c]) begin errors++; $display("FAIL bp_valid[%0d] got %b want %b", c, out_valid, ov_t[c]); end
            checks++; if (out_data !== od_t[c]) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", c, out_data, od_t[c]); end
            checks++; if (in_ready !== ir_t[c]) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want %b", c, in_ready, ir_t[c]); end
            if (c == 4 || c == 7) begin
                checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL bp_stall_count[%0d] got %0d want 3", c, stall_count); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        logic        fl_t [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
        logic        iv_t [8] = '{1, 1, 1, 0, 1, 1, 0, 0};
        logic [63:0] id_t [8] = '{64'hA1, 64'hB1, 64'hC1, 64'h0, 64'hD1, 64'hE1, 64'h0, 64'h0};
        logic        or_t [8] = '{0, 0, 0, 1, 0, 0, 1, 1};
        logic        ov_t [8] = '{0, 1, 1, 0, 0, 1, 0, 0};
        logic [63:0] od_t [8] = '{BUB64, 64'hA1, 64'hA1, BUB64, BUB64, 64'hD1, BUB64, BUB64};
        logic        ir_t [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        for (int c = 0; c < 8; c++) begin
            flush = fl_t[c]; in_valid = iv_t[c]; in_data = id_t[c]; out_ready = or_t[c];
            @(negedge clk);
            checks++; if (out_valid !== ov_t[c]) begin errors++; $display("FAIL flush_valid[%0d] got %b want %b", c, out_valid, ov_t[c]); end
            checks++; if (out_data !== od_t[c]) begin errors++; $display("FAIL flush_data[%0d] got %h want %h", c, out_data, od_t[c]); end
            checks++; if (in_ready !== ir_t[c]) begin errors++; $display("FAIL flush_in_ready[%0d] got %b want %b", c, in_ready, ir_t[c]); end
            if (c == 3) begin
                checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL flush_stall_kept got %0d want 5", stall_count); end
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b0;
        tick();
        s_in_valid = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            exp_cnt = (i - 1 > 15) ? 4'd15 : 4'(i - 1);
            @(negedge clk);
            checks++; if (s_stall_count !== exp_cnt) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", i, s_stall_count, exp_cnt); end
            checks++; if (s_out_data !== 8'h5A) begin errors++; $display("FAIL sat_data_stable[%0d] got %h want 5a", i, s_out_data); end
            tick();
        end
        s_out_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL sat_drain_valid got %b want 0", s_out_valid); end
        checks++; if (s_stall_count !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", s_stall_count); end
        tick();
    endtask

    task automatic test_plain();
        logic       iv_t [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [7:0] id_t [7] = '{8'h21, 8'h22, 8'h22, 8'h23, 8'h00, 8'h00, 8'h00};
        logic       or_t [7] = '{1, 0, 1, 1, 0, 1, 1};
        logic       ov_t [7] = '{0, 1, 1, 1, 1, 1, 0};
        logic [7:0] od_t [7] = '{BUB8, 8'h21, 8'h21, 8'h22, 8'h23, 8'h23, BUB8};
        logic       ir_t [7] = '{1, 0, 1, 1, 0, 1, 1};
        for (int c = 0; c < 7; c++) begin
            p_in_valid = iv_t[c]; p_in_data = id_t[c]; p_out_ready = or_t[c];
            @(negedge clk);
            checks++; if (p_out_valid !== ov_t[c]) begin errors++; $display("FAIL plain_valid[%0d] got %b want %b", c, p_out_valid, ov_t[c]); end
            checks++; if (p_out_data !== od_t[c]) begin errors++; $display("FAIL plain_data[%0d] got %h want %h", c, p_out_data, od_t[c]); end
            checks++; if (p_in_ready !== ir_t[c]) begin errors++; $display("FAIL plain_in_ready[%0d] got %b want %b", c, p_in_ready, ir_t[c]); end
            tick();
        end
        p_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        in_valid = 1'b1; in_data = 64'h77; out_ready = 1'b0;
        tick();
        in_data = 64'h88;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        checks++; if (out_data !== BUB64) begin errors++; $display("FAIL midrst_data got %h want %h", out_data, BUB64); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL midrst_stall got %0d want 0", stall_count); end
        @(posedge clk); #1 reset = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_emit[%0d] got %b want 0", c, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_plain();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
